compute_issue_seq: RTL and testbench
====================================

Name: compute_issue_seq

Overview:
- Sequencer that sits directly downstream of the compute instruction queue and drives the compute stage's execution units.
- Accepts one 128-bit compute instruction at a time and decodes it internally: opcode, dependency flags, xsize, ALU op.
- Acquires the dependency tokens the instruction needs, starts the matching unit (uop load, acc load, GEMM, ALU), waits for completion, then releases tokens.
- Provides the token handshakes between compute and the load/store stages; instructions are serialized, never overlapped.

Parameters:
- INST_W, 128, instruction width (fixed field map below).
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- io_inst_valid  in  1  instruction available
- io_inst_ready  out  1  sequencer accepts instruction
- io_inst_bits  in  INST_W  instruction
- io_l2g_valid  in  1  load-to-compute token available (consumed by pop_prev)
- io_l2g_ready  out  1  token consumed
- io_s2g_valid  in  1  store-to-compute token available (consumed by pop_next)
- io_s2g_ready  out  1  token consumed
- io_g2l_valid  out  1  compute-to-load token (push_prev)
- io_g2l_ready  in  1  token accepted
- io_g2s_valid  out  1  compute-to-store token (push_next)
- io_g2s_ready  in  1  token accepted
- io_exec_inst  out  INST_W  registered copy of current instruction, stable from accept until return to IDLE
- io_uop_start, io_acc_start, io_gemm_start, io_alu_start  out  1 each  one-cycle start pulses
- io_exec_done  in  1  one-cycle completion pulse from the started unit
- io_finish  out  1  one-cycle pulse for FINISH
- io_illegal  out  1  one-cycle pulse on illegal instruction
- io_retired  out  CNT_W  retired-instruction count

Behaviour:
- Field map: opcode [2:0]; pop_prev [3]; pop_next [4]; push_prev [5]; push_next [6]; mem type [8:7]; xsize [95:80]; ALU op [110:108].
- Classes:
  - LOAD (opcode 0): mem type 0 = uop, mem type 3 = acc; xsize==0 = SYNC.
  - GEMM = 2; FINISH = 3; ALU = 4 with ALU op 0..3.
  - Anything else is ILLEGAL: LOAD with mem type 1/2, opcode 1/5/6/7, ALU op 4..7.
- Reset: state IDLE; all valid/ready/start/finish/illegal outputs 0; io_retired 0; io_exec_inst 0; token flags cleared. Reset mid-operation discards the current instruction and any pending tokens with no further pulses.
- FSM states and transitions:
  - IDLE: io_inst_ready=1. On valid&ready, register the instruction, set need_l2g=pop_prev and need_s2g=pop_next, go to POP.
  - POP: io_l2g_ready=need_l2g and io_s2g_ready=need_s2g. Each flag clears on its own handshake; the two may complete in the same cycle or in either order. With both flags clear, next state is:
    - EXEC for uop, acc, GEMM and ALU;
    - PUSH for SYNC;
    - PUSH for FINISH, pulsing io_finish in the transition cycle;
    - PUSH for ILLEGAL, pulsing io_illegal in the transition cycle.
    - If neither pop is required, POP lasts exactly one cycle.
  - EXEC: exactly one start pulse for one cycle, chosen by class; go to WAIT.
  - WAIT: hold until io_exec_done; go to PUSH. io_exec_done in any other state is ignored.
  - PUSH: io_g2l_valid=push_prev-pending and io_g2s_valid=push_next-pending, each held until its own ready, then cleared independently. When both are clear, io_retired increments (wraps at 2^CNT_W) and the FSM returns to IDLE. If no push is required, PUSH lasts one cycle.
- Latency: accept to start pulse is 2 cycles with no pop stalls. A GEMM with no tokens and done one cycle after start retires 5 cycles after accept (IDLE, POP, EXEC, WAIT, PUSH).
- No new instruction is accepted before the previous one returns to IDLE; io_inst_ready is 0 outside IDLE.
- Token ready/valid are never asserted for tokens the instruction does not request.
- ILLEGAL instructions still honour all four dependency flags, so the token chain cannot deadlock.

Decomposition:
- Shared package holds:
  - opcode constants (LOAD=0, GEMM=2, FINISH=3, ALU=4);
  - mem-type constants (UOP=0, ACC=3);
  - field bit positions;
  - FSM state encoding.
- One natural sub-module: compute_inst_classify, a purely combinational instruction-to-class one-hot decode that produces uop/acc/sync/gemm/alu/finish/illegal plus the four flags. The sequencer instantiates it on the registered instruction.

Test Plan:
- GEMM inst 0x...02, no flags, io_exec_done 1 cycle after start -> io_gemm_start pulses 2 cycles after accept; io_retired=1 after 5 cycles; no token activity.
- ALU inst (opcode 4, ALU op 2) with pop_prev=1 and io_l2g_valid delayed 3 cycles -> io_l2g_ready held 3 cycles; io_alu_start only after the handshake.
- SYNC (opcode 0, mem type 0, xsize=0) with push_prev=1 and push_next=1, io_g2s_ready 2 cycles later than io_g2l_ready -> no start pulse; each valid drops independently; retire after both handshakes.
- Load-acc (mem type 3, xsize=16) with pop_prev=1, pop_next=1 and both tokens valid -> both readies in the same cycle; io_acc_start the next cycle.
- FINISH (opcode 3) -> single io_finish pulse; io_inst_ready low until PUSH completes; ILLEGAL (opcode 6, push_next=1) -> single io_illegal pulse and the g2s token still pushed.
- Assert reset while in WAIT with push flags set -> all outputs 0 next cycle, io_retired=0, no g2l/g2s valid afterwards; the next instruction is accepted normally.

Source files
------------

// File: rtl/compute_issue_seq_pkg.sv
// Shared constants and types for the compute-stage issue sequencer.
// Covers the instruction field map, opcode and mem-type codes, class one-hot and FSM encoding.
package compute_issue_seq_pkg;

  localparam int unsigned InstW = 128;
  localparam int unsigned CntW  = 32;

  // Instruction field map
  localparam int unsigned OpcLsb      = 0;
  localparam int unsigned OpcW        = 3;
  localparam int unsigned PopPrevBit  = 3;
  localparam int unsigned PopNextBit  = 4;
  localparam int unsigned PushPrevBit = 5;
  localparam int unsigned PushNextBit = 6;
  localparam int unsigned MemLsb      = 7;
  localparam int unsigned MemW        = 2;
  localparam int unsigned XsizeLsb    = 80;
  localparam int unsigned XsizeW      = 16;
  localparam int unsigned AluLsb      = 108;
  localparam int unsigned AluW        = 3;

  localparam logic [OpcW-1:0] OpcLoad   = 3'd0;
  localparam logic [OpcW-1:0] OpcGemm   = 3'd2;
  localparam logic [OpcW-1:0] OpcFinish = 3'd3;
  localparam logic [OpcW-1:0] OpcAlu    = 3'd4;

  localparam logic [MemW-1:0] MemUop = 2'd0;
  localparam logic [MemW-1:0] MemAcc = 2'd3;

  localparam logic [AluW-1:0] AluOpMax = 3'd3;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StPop  = 3'd1,
    StExec = 3'd2,
    StWait = 3'd3,
    StPush = 3'd4
  } seqState_t;

  typedef struct packed {
    logic uop;
    logic acc;
    logic sync;
    logic gemm;
    logic alu;
    logic finish;
    logic illegal;
  } instClass_t;

  typedef struct packed {
    logic popPrev;
    logic popNext;
    logic pushPrev;
    logic pushNext;
  } depFlags_t;

endpackage

// File: rtl/compute_inst_classify.sv
// Combinational decode of a compute instruction into a one-hot class plus its four dependency flags.
module compute_inst_classify
  import compute_issue_seq_pkg::*;
(
  input  logic [InstW-1:0] inst,
  output instClass_t       cls,
  output depFlags_t        flags
);

  logic [OpcW-1:0]   opcode;
  logic [MemW-1:0]   memType;
  logic [XsizeW-1:0] xsize;
  logic [AluW-1:0]   aluOp;
  logic              unusedBits;

  assign opcode  = inst[OpcLsb +: OpcW];
  assign memType = inst[MemLsb +: MemW];
  assign xsize   = inst[XsizeLsb +: XsizeW];
  assign aluOp   = inst[AluLsb +: AluW];

  // Immediate/address fields are carried to the units untouched
  assign unusedBits = ^{inst[InstW-1:AluLsb+AluW],
                        inst[AluLsb-1:XsizeLsb+XsizeW],
                        inst[XsizeLsb-1:MemLsb+MemW]};

  assign flags.popPrev  = inst[PopPrevBit];
  assign flags.popNext  = inst[PopNextBit];
  assign flags.pushPrev = inst[PushPrevBit];
  assign flags.pushNext = inst[PushNextBit];

  // Exactly one class bit is set for any instruction
  always_comb begin
    cls = '0;
    case (opcode)
      OpcLoad: begin
        if ((memType != MemUop) && (memType != MemAcc)) cls.illegal = 1'b1;
        else if (xsize == '0)                           cls.sync    = 1'b1;
        else if (memType == MemUop)                     cls.uop     = 1'b1;
        else                                            cls.acc     = 1'b1;
      end
      OpcGemm:   cls.gemm   = 1'b1;
      OpcFinish: cls.finish = 1'b1;
      OpcAlu: begin
        if (aluOp > AluOpMax) cls.illegal = 1'b1;
        else                  cls.alu     = 1'b1;
      end
      default:   cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/compute_issue_seq.sv
// Compute-stage issue sequencer: takes one instruction at a time, pops dependency tokens,
// runs the selected unit to completion, pushes tokens, then retires.
module compute_issue_seq
  import compute_issue_seq_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             io_inst_valid,
  output logic             io_inst_ready,
  input  logic [InstW-1:0] io_inst_bits,
  input  logic             io_l2g_valid,
  output logic             io_l2g_ready,
  input  logic             io_s2g_valid,
  output logic             io_s2g_ready,
  output logic             io_g2l_valid,
  input  logic             io_g2l_ready,
  output logic             io_g2s_valid,
  input  logic             io_g2s_ready,
  output logic [InstW-1:0] io_exec_inst,
  output logic             io_uop_start,
  output logic             io_acc_start,
  output logic             io_gemm_start,
  output logic             io_alu_start,
  input  logic             io_exec_done,
  output logic             io_finish,
  output logic             io_illegal,
  output logic [CntW-1:0]  io_retired
);

  seqState_t        state;
  seqState_t        stateNext;
  logic [InstW-1:0] instQ;
  logic [CntW-1:0]  retired;
  instClass_t       cls;
  depFlags_t        flags;

  // Per-token "already handled" flags; cleared on accept
  logic l2gDone, s2gDone, g2lDone, g2sDone;
  logic l2gDoneNext, s2gDoneNext, g2lDoneNext, g2sDoneNext;
  logic needL2g, needS2g, needG2l, needG2s;
  logic accept, retire;

  compute_inst_classify uClassify (
    .inst  (instQ),
    .cls   (cls),
    .flags (flags)
  );

  assign needL2g = flags.popPrev  & ~l2gDone;
  assign needS2g = flags.popNext  & ~s2gDone;
  assign needG2l = flags.pushPrev & ~g2lDone;
  assign needG2s = flags.pushNext & ~g2sDone;

  // Next-state and handshake/pulse decode
  always_comb begin
    stateNext     = state;
    l2gDoneNext   = l2gDone;
    s2gDoneNext   = s2gDone;
    g2lDoneNext   = g2lDone;
    g2sDoneNext   = g2sDone;
    accept        = 1'b0;
    retire        = 1'b0;
    io_inst_ready = 1'b0;
    io_l2g_ready  = 1'b0;
    io_s2g_ready  = 1'b0;
    io_g2l_valid  = 1'b0;
    io_g2s_valid  = 1'b0;
    io_uop_start  = 1'b0;
    io_acc_start  = 1'b0;
    io_gemm_start = 1'b0;
    io_alu_start  = 1'b0;
    io_finish     = 1'b0;
    io_illegal    = 1'b0;
    if (!reset) begin
      case (state)
        StIdle: begin
          io_inst_ready = 1'b1;
          if (io_inst_valid) begin
            accept      = 1'b1;
            l2gDoneNext = 1'b0;
            s2gDoneNext = 1'b0;
            g2lDoneNext = 1'b0;
            g2sDoneNext = 1'b0;
            stateNext   = StPop;
          end
        end
        StPop: begin
          io_l2g_ready = needL2g;
          io_s2g_ready = needS2g;
          if (needL2g && io_l2g_valid) l2gDoneNext = 1'b1;
          if (needS2g && io_s2g_valid) s2gDoneNext = 1'b1;
          // Leave as soon as the last outstanding pop completes this cycle
          if ((!needL2g || io_l2g_valid) && (!needS2g || io_s2g_valid)) begin
            io_finish  = cls.finish;
            io_illegal = cls.illegal;
            if (cls.sync || cls.finish || cls.illegal) stateNext = StPush;
            else                                       stateNext = StExec;
          end
        end
        StExec: begin
          io_uop_start  = cls.uop;
          io_acc_start  = cls.acc;
          io_gemm_start = cls.gemm;
          io_alu_start  = cls.alu;
          stateNext     = StWait;
        end
        StWait: begin
          if (io_exec_done) stateNext = StPush;
        end
        StPush: begin
          io_g2l_valid = needG2l;
          io_g2s_valid = needG2s;
          if (needG2l && io_g2l_ready) g2lDoneNext = 1'b1;
          if (needG2s && io_g2s_ready) g2sDoneNext = 1'b1;
          if ((!needG2l || io_g2l_ready) && (!needG2s || io_g2s_ready)) begin
            retire    = 1'b1;
            stateNext = StIdle;
          end
        end
        default: stateNext = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= StIdle;
      instQ   <= '0;
      retired <= '0;
      l2gDone <= 1'b0;
      s2gDone <= 1'b0;
      g2lDone <= 1'b0;
      g2sDone <= 1'b0;
    end else begin
      state   <= stateNext;
      l2gDone <= l2gDoneNext;
      s2gDone <= s2gDoneNext;
      g2lDone <= g2lDoneNext;
      g2sDone <= g2sDoneNext;
      if (accept) instQ   <= io_inst_bits;
      if (retire) retired <= retired + CntW'(1);
    end
  end

  assign io_exec_inst = instQ;
  assign io_retired   = retired;

endmodule

// File: tb/tb_compute_issue_seq.sv
// Self-checking bench for compute_issue_seq: directed scenarios plus randomized instructions
// checked against a cycle-count reference model of the sequencing rules.
`timescale 1ns/1ps
module tb_compute_issue_seq;

  localparam int CUop = 0, CAcc = 1, CSync = 2, CGemm = 3, CAlu = 4, CFin = 5, CIll = 6;

  logic         clock;
  logic         reset;
  logic         io_inst_valid, io_inst_ready;
  logic [127:0] io_inst_bits;
  logic         io_l2g_valid, io_l2g_ready, io_s2g_valid, io_s2g_ready;
  logic         io_g2l_valid, io_g2l_ready, io_g2s_valid, io_g2s_ready;
  logic [127:0] io_exec_inst;
  logic         io_uop_start, io_acc_start, io_gemm_start, io_alu_start;
  logic         io_exec_done, io_finish, io_illegal;
  logic [31:0]  io_retired;

  int          nChecks;
  int          nFail;
  logic [31:0] expRetired;

  compute_issue_seq dut (
    .clock(clock), .reset(reset),
    .io_inst_valid(io_inst_valid), .io_inst_ready(io_inst_ready), .io_inst_bits(io_inst_bits),
    .io_l2g_valid(io_l2g_valid), .io_l2g_ready(io_l2g_ready),
    .io_s2g_valid(io_s2g_valid), .io_s2g_ready(io_s2g_ready),
    .io_g2l_valid(io_g2l_valid), .io_g2l_ready(io_g2l_ready),
    .io_g2s_valid(io_g2s_valid), .io_g2s_ready(io_g2s_ready),
    .io_exec_inst(io_exec_inst),
    .io_uop_start(io_uop_start), .io_acc_start(io_acc_start),
    .io_gemm_start(io_gemm_start), .io_alu_start(io_alu_start),
    .io_exec_done(io_exec_done), .io_finish(io_finish), .io_illegal(io_illegal),
    .io_retired(io_retired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int startCyc, uopN, accN, gemmN, aluN, finN, finCyc, illN, illCyc;
    int l2gRdy, s2gRdy, g2lVal, g2sVal, l2gHs, s2gHs, g2lHs, g2sHs;
    int retireCyc, busyReady;
    logic [127:0] execInst;
    logic [31:0]  retiredAfter;
  } obs_t;

  typedef struct {
    int cls, popEnd, startCyc, pushStart, retireCyc;
    int l2gRdy, s2gRdy, g2lVal, g2sVal;
  } exp_t;

  function automatic int refClass(input logic [127:0] inst);
    int op, mt, xs, aop;
    op  = int'(inst[2:0]);
    mt  = int'(inst[8:7]);
    xs  = int'(inst[95:80]);
    aop = int'(inst[110:108]);
    if (op == 0) begin
      if (mt == 1 || mt == 2) return CIll;
      if (xs == 0) return CSync;
      return (mt == 0) ? CUop : CAcc;
    end
    if (op == 2) return CGemm;
    if (op == 3) return CFin;
    if (op == 4) return (aop < 4) ? CAlu : CIll;
    return CIll;
  endfunction

  // Cycle numbers are counted from the accept cycle (0)
  function automatic exp_t refModel(input logic [127:0] inst, input int dl2g, input int ds2g,
                                    input int dg2l, input int dg2s, input int ddone);
    exp_t e;
    int   q;
    e.cls    = refClass(inst);
    e.l2gRdy = inst[3] ? ((dl2g > 1) ? dl2g : 1) : 0;
    e.s2gRdy = inst[4] ? ((ds2g > 1) ? ds2g : 1) : 0;
    e.popEnd = 1;
    if (e.l2gRdy > e.popEnd) e.popEnd = e.l2gRdy;
    if (e.s2gRdy > e.popEnd) e.popEnd = e.s2gRdy;
    if (e.cls == CUop || e.cls == CAcc || e.cls == CGemm || e.cls == CAlu) begin
      e.startCyc  = e.popEnd + 1;
      e.pushStart = e.popEnd + 2 + ddone;
    end else begin
      e.startCyc  = -1;
      e.pushStart = e.popEnd + 1;
    end
    e.g2lVal = inst[5] ? dg2l + 1 : 0;
    e.g2sVal = inst[6] ? dg2s + 1 : 0;
    q = e.pushStart;
    if (inst[5] && e.pushStart + dg2l > q) q = e.pushStart + dg2l;
    if (inst[6] && e.pushStart + dg2s > q) q = e.pushStart + dg2s;
    e.retireCyc = q + 1;
    return e;
  endfunction

  function automatic logic [127:0] randInst();
    logic [127:0] v;
    int           pick, t;
    v    = {$urandom, $urandom, $urandom, $urandom};
    pick = $urandom_range(0, 9);
    case (pick)
      0: begin v[2:0] = 3'd0; v[8:7] = 2'd0; v[95:80] = 16'($urandom_range(1, 65535)); end
      1: begin v[2:0] = 3'd0; v[8:7] = 2'd3; v[95:80] = 16'($urandom_range(1, 65535)); end
      2: begin v[2:0] = 3'd0; v[8:7] = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3; v[95:80] = 16'd0; end
      3: v[2:0] = 3'd2;
      4: begin v[2:0] = 3'd4; v[110:108] = 3'($urandom_range(0, 3)); end
      5: v[2:0] = 3'd3;
      6: begin v[2:0] = 3'd4; v[110:108] = 3'($urandom_range(4, 7)); end
      7: begin v[2:0] = 3'd0; v[8:7] = 2'($urandom_range(1, 2)); end
      8: begin t = $urandom_range(0, 3); v[2:0] = (t == 0) ? 3'd1 : 3'(t + 4); end
      default: ;
    endcase
    return v;
  endfunction

  task automatic idleInputs();
    io_inst_valid = 1'b0;
    io_l2g_valid  = 1'b0;
    io_s2g_valid  = 1'b0;
    io_g2l_ready  = 1'b0;
    io_g2s_ready  = 1'b0;
    io_exec_done  = 1'b0;
  endtask

  // Drives one instruction to completion; token valids are offered even when not requested
  task automatic runInst(input logic [127:0] inst, input int dl2g, input int ds2g, input int dg2l,
                         input int dg2s, input int ddone, input int pushStart, output obs_t o);
    bit l2gGot, s2gGot, finished;
    int doneAt;
    o = '{default: 0};
    o.startCyc = -1; o.finCyc = -1; o.illCyc = -1; o.retireCyc = -1;
    l2gGot = 0; s2gGot = 0; finished = 0; doneAt = -1;
    for (int k = 0; k < 300 && !finished; k++) begin
      @(posedge clock); #1;
      io_inst_valid = (k == 0);
      io_inst_bits  = inst;
      io_l2g_valid  = !l2gGot && (k >= dl2g);
      io_s2g_valid  = !s2gGot && (k >= ds2g);
      io_g2l_ready  = (k >= pushStart + dg2l);
      io_g2s_ready  = (k >= pushStart + dg2s);
      io_exec_done  = (k == 0) || (k == doneAt);
      @(negedge clock);
      if (io_uop_start)  o.uopN++;
      if (io_acc_start)  o.accN++;
      if (io_gemm_start) o.gemmN++;
      if (io_alu_start)  o.aluN++;
      if ((io_uop_start || io_acc_start || io_gemm_start || io_alu_start) && o.startCyc < 0) begin
        o.startCyc = k;
        doneAt     = k + ddone;
      end
      if (io_finish)  begin o.finN++; if (o.finCyc < 0) o.finCyc = k; end
      if (io_illegal) begin o.illN++; if (o.illCyc < 0) o.illCyc = k; end
      if (io_l2g_ready) o.l2gRdy++;
      if (io_s2g_ready) o.s2gRdy++;
      if (io_g2l_valid) o.g2lVal++;
      if (io_g2s_valid) o.g2sVal++;
      if (io_l2g_ready && io_l2g_valid) begin o.l2gHs++; l2gGot = 1; end
      if (io_s2g_ready && io_s2g_valid) begin o.s2gHs++; s2gGot = 1; end
      if (io_g2l_valid && io_g2l_ready) o.g2lHs++;
      if (io_g2s_valid && io_g2s_ready) o.g2sHs++;
      if (k == 1) o.execInst = io_exec_inst;
      if (k > 0 && io_retired !== expRetired) begin
        o.retireCyc    = k;
        o.retiredAfter = io_retired;
        finished       = 1;
      end else if (k > 0 && io_inst_ready) begin
        o.busyReady++;
      end
    end
    idleInputs();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idleInputs();
    io_inst_valid = 1'b1;
    io_l2g_valid  = 1'b1;
    io_inst_bits  = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    nChecks++; if (io_inst_ready !== 1'b0) begin nFail++; $display("FAIL reset_inst_ready: got %0b want 0", io_inst_ready); end
    nChecks++; if (io_l2g_ready !== 1'b0) begin nFail++; $display("FAIL reset_l2g_ready: got %0b want 0", io_l2g_ready); end
    nChecks++; if ({io_g2l_valid, io_g2s_valid, io_uop_start, io_acc_start, io_gemm_start, io_alu_start, io_finish, io_illegal} !== 8'h00)
      begin nFail++; $display("FAIL reset_pulses: got %b want 0", {io_g2l_valid, io_g2s_valid, io_uop_start, io_acc_start, io_gemm_start, io_alu_start, io_finish, io_illegal}); end
    nChecks++; if (io_retired !== 32'd0) begin nFail++; $display("FAIL reset_retired: got %0d want 0", io_retired); end
    nChecks++; if (io_exec_inst !== 128'd0) begin nFail++; $display("FAIL reset_exec_inst: got %h want 0", io_exec_inst); end
    @(posedge clock); #1;
    reset = 1'b0;
    idleInputs();
    @(negedge clock);
    nChecks++; if (io_inst_ready !== 1'b1) begin nFail++; $display("FAIL idle_inst_ready: got %0b want 1", io_inst_ready); end
    expRetired = 32'd0;
  endtask

  task automatic test_gemm_basic();
    logic [127:0] inst;
    obs_t         o;
    inst = {$urandom, $urandom, $urandom, $urandom};
    inst[6:0] = 7'h02;
    runInst(inst, 0, 0, 0, 0, 1, 4, o);
    expRetired++;
    nChecks++; if (o.gemmN !== 1 || o.uopN + o.accN + o.aluN !== 0) begin nFail++; $display("FAIL gemm_starts: got gemm=%0d other=%0d want 1/0", o.gemmN, o.uopN + o.accN + o.aluN); end
    nChecks++; if (o.startCyc !== 2) begin nFail++; $display("FAIL gemm_start_latency: got %0d want 2", o.startCyc); end
    nChecks++; if (o.retireCyc !== 5) begin nFail++; $display("FAIL gemm_retire_latency: got %0d want 5", o.retireCyc); end
    nChecks++; if (o.l2gRdy + o.s2gRdy + o.g2lVal + o.g2sVal !== 0) begin nFail++; $display("FAIL gemm_token_activity: got %0d want 0", o.l2gRdy + o.s2gRdy + o.g2lVal + o.g2sVal); end
    nChecks++; if (o.retiredAfter !== expRetired) begin nFail++; $display("FAIL gemm_retired: got %0d want %0d", o.retiredAfter, expRetired); end
    nChecks++; if (o.execInst !== inst) begin nFail++; $display("FAIL gemm_exec_inst: got %h want %h", o.execInst, inst); end
  endtask

  task automatic test_alu_pop_stall();
    logic [127:0] inst;
    obs_t         o;
    inst = {$urandom, $urandom, $urandom, $urandom};
    inst[6:0] = 7'b0001_100;
    inst[110:108] = 3'd2;
    runInst(inst, 3, 0, 0, 0, 2, 7, o);
    expRetired++;
    nChecks++; if (o.l2gRdy !== 3) begin nFail++; $display("FAIL alu_l2g_ready_cycles: got %0d want 3", o.l2gRdy); end
    nChecks++; if (o.l2gHs !== 1 || o.s2gRdy !== 0) begin nFail++; $display("FAIL alu_pop: got hs=%0d s2gRdy=%0d want 1/0", o.l2gHs, o.s2gRdy); end
    nChecks++; if (o.aluN !== 1 || o.startCyc !== 4) begin nFail++; $display("FAIL alu_start: got n=%0d cyc=%0d want 1/4", o.aluN, o.startCyc); end
    nChecks++; if (o.retireCyc !== 8) begin nFail++; $display("FAIL alu_retire: got %0d want 8", o.retireCyc); end
  endtask

  task automatic test_sync_push();
    logic [127:0] inst;
    obs_t         o;
    inst = {$urandom, $urandom, $urandom, $urandom};
    inst[8:0] = 9'b00_1100_000;
    inst[95:80] = 16'd0;
    runInst(inst, 0, 0, 0, 2, 1, 2, o);
    expRetired++;
    nChecks++; if (o.uopN + o.accN + o.gemmN + o.aluN !== 0) begin nFail++; $display("FAIL sync_no_start: got %0d want 0", o.uopN + o.accN + o.gemmN + o.aluN); end
    nChecks++; if (o.g2lVal !== 1 || o.g2sVal !== 3) begin nFail++; $display("FAIL sync_push_valids: got g2l=%0d g2s=%0d want 1/3", o.g2lVal, o.g2sVal); end
    nChecks++; if (o.g2lHs !== 1 || o.g2sHs !== 1) begin nFail++; $display("FAIL sync_push_hs: got %0d/%0d want 1/1", o.g2lHs, o.g2sHs); end
    nChecks++; if (o.retireCyc !== 5 || o.retiredAfter !== expRetired) begin nFail++; $display("FAIL sync_retire: got cyc=%0d cnt=%0d want 5/%0d", o.retireCyc, o.retiredAfter, expRetired); end
  endtask

  task automatic test_acc_dual_pop();
    logic [127:0] inst;
    obs_t         o;
    inst = {$urandom, $urandom, $urandom, $urandom};
    inst[8:0] = 9'b11_0011_000;
    inst[95:80] = 16'd16;
    runInst(inst, 0, 0, 0, 0, 1, 4, o);
    expRetired++;
    nChecks++; if (o.l2gRdy !== 1 || o.s2gRdy !== 1) begin nFail++; $display("FAIL acc_dual_ready: got %0d/%0d want 1/1", o.l2gRdy, o.s2gRdy); end
    nChecks++; if (o.accN !== 1 || o.startCyc !== 2) begin nFail++; $display("FAIL acc_start: got n=%0d cyc=%0d want 1/2", o.accN, o.startCyc); end
  endtask

  task automatic test_finish_illegal();
    logic [127:0] inst;
    obs_t         o;
    inst = {$urandom, $urandom, $urandom, $urandom};
    inst[6:0] = 7'h03;
    runInst(inst, 0, 0, 0, 0, 1, 2, o);
    expRetired++;
    nChecks++; if (o.finN !== 1 || o.finCyc !== 1) begin nFail++; $display("FAIL finish_pulse: got n=%0d cyc=%0d want 1/1", o.finN, o.finCyc); end
    nChecks++; if (o.busyReady !== 0) begin nFail++; $display("FAIL finish_inst_ready_busy: got %0d want 0", o.busyReady); end
    nChecks++; if (o.retireCyc !== 3) begin nFail++; $display("FAIL finish_retire: got %0d want 3", o.retireCyc); end
    inst = {$urandom, $urandom, $urandom, $urandom};
    inst[6:0] = 7'b1000_110;
    runInst(inst, 0, 0, 0, 1, 1, 2, o);
    expRetired++;
    nChecks++; if (o.illN !== 1 || o.finN !== 0) begin nFail++; $display("FAIL illegal_pulse: got ill=%0d fin=%0d want 1/0", o.illN, o.finN); end
    nChecks++; if (o.g2sHs !== 1 || o.g2lVal !== 0) begin nFail++; $display("FAIL illegal_g2s_push: got hs=%0d g2l=%0d want 1/0", o.g2sHs, o.g2lVal); end
    nChecks++; if (o.uopN + o.accN + o.gemmN + o.aluN !== 0) begin nFail++; $display("FAIL illegal_no_start: got %0d want 0", o.uopN + o.accN + o.gemmN + o.aluN); end
  endtask

  task automatic test_reset_mid_wait();
    logic [127:0] inst;
    obs_t         o;
    int           tokCnt;
    inst = {$urandom, $urandom, $urandom, $urandom};
    inst[6:0] = 7'b1100_010;
    @(posedge clock); #1;
    io_inst_valid = 1'b1;
    io_inst_bits  = inst;
    @(posedge clock); #1;
    io_inst_valid = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    nChecks++; if (io_gemm_start !== 1'b1) begin nFail++; $display("FAIL rst_pre_gemm_start: got %0b want 1", io_gemm_start); end
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    nChecks++; if ({io_inst_ready, io_g2l_valid, io_g2s_valid} !== 3'b000) begin nFail++; $display("FAIL rst_during: got %b want 000", {io_inst_ready, io_g2l_valid, io_g2s_valid}); end
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    nChecks++; if (io_retired !== 32'd0 || io_exec_inst !== 128'd0) begin nFail++; $display("FAIL rst_state: got retired=%0d inst=%h want 0/0", io_retired, io_exec_inst); end
    tokCnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      io_exec_done = (i == 0);
      @(negedge clock);
      if (io_g2l_valid || io_g2s_valid || io_gemm_start) tokCnt++;
    end
    io_exec_done = 1'b0;
    nChecks++; if (tokCnt !== 0) begin nFail++; $display("FAIL rst_no_stale_activity: got %0d want 0", tokCnt); end
    nChecks++; if (io_retired !== 32'd0) begin nFail++; $display("FAIL rst_retired_hold: got %0d want 0", io_retired); end
    expRetired = 32'd0;
    inst[6:0] = 7'b0100_010;
    runInst(inst, 0, 0, 0, 0, 1, 4, o);
    expRetired++;
    nChecks++; if (o.retiredAfter !== 32'd1 || o.g2lHs !== 1) begin nFail++; $display("FAIL rst_next_inst: got cnt=%0d hs=%0d want 1/1", o.retiredAfter, o.g2lHs); end
  endtask

  task automatic test_random(input int n);
    logic [127:0] inst;
    obs_t         o;
    exp_t         e;
    int           dl, ds, dgl, dgs, dd;
    for (int i = 0; i < n; i++) begin
      inst = randInst();
      dl = $urandom_range(0, 4); ds = $urandom_range(0, 4);
      dgl = $urandom_range(0, 3); dgs = $urandom_range(0, 3); dd = $urandom_range(1, 3);
      e = refModel(inst, dl, ds, dgl, dgs, dd);
      runInst(inst, dl, ds, dgl, dgs, dd, e.pushStart, o);
      expRetired++;
      nChecks++; if (o.uopN !== ((e.cls == CUop) ? 1 : 0) || o.accN !== ((e.cls == CAcc) ? 1 : 0) ||
                     o.gemmN !== ((e.cls == CGemm) ? 1 : 0) || o.aluN !== ((e.cls == CAlu) ? 1 : 0))
        begin nFail++; $display("FAIL rnd%0d_starts: got u/a/g/l=%0d/%0d/%0d/%0d want class %0d inst=%h", i, o.uopN, o.accN, o.gemmN, o.aluN, e.cls, inst); end
      nChecks++; if (o.startCyc !== e.startCyc) begin nFail++; $display("FAIL rnd%0d_start_cyc: got %0d want %0d", i, o.startCyc, e.startCyc); end
      nChecks++; if (o.finN !== ((e.cls == CFin) ? 1 : 0) || o.illN !== ((e.cls == CIll) ? 1 : 0))
        begin nFail++; $display("FAIL rnd%0d_fin_ill: got %0d/%0d want class %0d", i, o.finN, o.illN, e.cls); end
      nChecks++; if ((e.cls == CFin && o.finCyc !== e.popEnd) || (e.cls == CIll && o.illCyc !== e.popEnd))
        begin nFail++; $display("FAIL rnd%0d_pulse_cyc: got %0d/%0d want %0d", i, o.finCyc, o.illCyc, e.popEnd); end
      nChecks++; if (o.l2gRdy !== e.l2gRdy || o.s2gRdy !== e.s2gRdy)
        begin nFail++; $display("FAIL rnd%0d_pop_ready: got %0d/%0d want %0d/%0d", i, o.l2gRdy, o.s2gRdy, e.l2gRdy, e.s2gRdy); end
      nChecks++; if (o.g2lVal !== e.g2lVal || o.g2sVal !== e.g2sVal)
        begin nFail++; $display("FAIL rnd%0d_push_valid: got %0d/%0d want %0d/%0d", i, o.g2lVal, o.g2sVal, e.g2lVal, e.g2sVal); end
      nChecks++; if (o.l2gHs !== int'(inst[3]) || o.s2gHs !== int'(inst[4]) || o.g2lHs !== int'(inst[5]) || o.g2sHs !== int'(inst[6]))
        begin nFail++; $display("FAIL rnd%0d_handshakes: got %0d%0d%0d%0d want %b", i, o.l2gHs, o.s2gHs, o.g2lHs, o.g2sHs, inst[6:3]); end
      nChecks++; if (o.retireCyc !== e.retireCyc || o.retiredAfter !== expRetired)
        begin nFail++; $display("FAIL rnd%0d_retire: got cyc=%0d cnt=%0d want %0d/%0d", i, o.retireCyc, o.retiredAfter, e.retireCyc, expRetired); end
      nChecks++; if (o.busyReady !== 0 || o.execInst !== inst)
        begin nFail++; $display("FAIL rnd%0d_busy_or_inst: got busy=%0d inst=%h want 0/%h", i, o.busyReady, o.execInst, inst); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nChecks    = 0;
    nFail      = 0;
    expRetired = 32'd0;
    reset      = 1'b1;
    io_inst_bits = '0;
    idleInputs();
    test_reset();
    test_gemm_basic();
    test_alu_pop_stall();
    test_sync_push();
    test_acc_dual_pop();
    test_finish_illegal();
    test_reset_mid_wait();
    test_random(40);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
